ramdp_mbox: RTL
===============

Name: ramdp_mbox

Overview:
- Parametrised dual-port shared RAM between the MCU (32-bit, synchronous) and the cartridge CPU bus (16-bit, asynchronous strobes).
- Adds configurable depth and address width, a configurable CPU write-strobe qualifier, byte-lane collision arbitration, and a two-way doorbell mailbox with interrupt outputs.
- Sits in the MCU clock domain as the MCU-to-CPU shared-memory and command channel.

Parameters:
- ADDR_W, 13: CPU/MCU byte-address width of the window; depth = 2^(ADDR_W-2) 32-bit words.
- CPU_AW, 24: CPU address bus width; window occupies CPU byte addresses 0 .. 2^ADDR_W-1.
- WE_HOLD, 2: consecutive high samples of the CPU write request needed to commit a write (range 1-4).

Ports:
- clk  in  1  MCU clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- mcu_ce  in  1  MCU access selects this block.
- mcu_addr  in  ADDR_W  MCU byte address; [ADDR_W-1:2] used.
- mcu_dato  in  32  MCU write data.
- mcu_we  in  4  MCU byte-lane write enables.
- mcu_dati  out  32  MCU read data.
- cpu_ce_lo  in  1  CPU chip enable (async).
- cpu_addr  in  CPU_AW  CPU byte address (async).
- cpu_dato  in  16  CPU write data.
- cpu_we_lo  in  1  CPU low-byte write strobe.
- cpu_we_hi  in  1  CPU high-byte write strobe.
- cpu_dati  out  16  CPU read data.
- mcu_irq  out  1  CPU-to-MCU doorbell pending.
- cpu_irq  out  1  MCU-to-CPU doorbell pending.
- coll  out  1  sticky byte-lane collision flag.
- coll_clr  in  1  MCU clears coll.

Behaviour:
- Storage: 2^(ADDR_W-2) x 32 bits as four byte lanes. Contents are not reset.
- MCU port:
  - Write lane i when mcu_ce & mcu_we[i], at word mcu_addr[ADDR_W-1:2].
  - mcu_dati is the registered read; 1-cycle latency.
- CPU lane map:
  - cpu_addr[1]=0 selects lanes 1:0; cpu_addr[1]=1 selects lanes 3:2.
  - cpu_we_lo writes the even lane from cpu_dato[7:0].
  - cpu_we_hi writes the odd lane from cpu_dato[15:8].
- CPU write qualification:
  - req = cpu_ce_lo & (cpu_we_lo|cpu_we_hi) & cpu_addr < 2^ADDR_W.
  - req is shifted into a history register each clk.
  - commit is a single-cycle pulse when the history shows one 0 followed by exactly WE_HOLD 1s (WE_HOLD=2: pattern 011, oldest first).
  - Address, data and strobes are used directly at commit; they are stable by then.
  - A held strobe commits once only.
- CPU read: cpu_dati = registered word, lane pair muxed by cpu_addr[1]; 1-cycle latency.
- Collision: commit and MCU write hit the same word and same lane in the same cycle.
  - CPU data wins that lane; MCU's other lanes are still written.
  - coll sets.
  - coll_clr clears coll; if a set and coll_clr occur in the same cycle, set wins.
- Doorbells (word indices, D = 2^(ADDR_W-2)):
  - CPU commit to word D-1 sets mcu_irq. MCU write to word D-1 (any lane) clears it.
  - MCU write to word D-2 (any lane) sets cpu_irq. CPU commit to word D-2 clears it.
  - Simultaneous set and clear of the same flag: set wins.
  - Data writes to both words proceed normally.
- Reset (async assert, sync release):
  - mcu_dati=0, cpu_dati=0, mcu_irq=0, cpu_irq=0, coll=0.
  - History register resets to all 1s, so a CPU write in progress across reset release is not committed.
- Out-of-window CPU address: no write, no doorbell effect. Reads return the word at cpu_addr[ADDR_W-1:2] (alias).
- Strobe glitch shorter than WE_HOLD samples: no commit.

Test Plan:
- MCU writes 0xA1B2C3D4 to byte address 0x10, CPU reads 0x10 and 0x12 -> cpu_dati 0xC3D4 then 0xA1B2, each 1 clk after address.
- CPU asserts we_hi only at 0x12, data 0x5500, strobe held 10 clks -> exactly one commit 2 clks after the rising sample; MCU reads 0x55B2C3D4.
- Same cycle: commit to 0x10 lane 0 (0x77) and MCU mcu_we=0xF with 0x11223344 -> word 0x11223377, coll=1; coll_clr -> coll=0.
- CPU commit to word D-1 -> mcu_irq=1; MCU write to D-1 -> mcu_irq=0. MCU write to D-2 -> cpu_irq=1; CPU commit to D-2 -> cpu_irq=0.
- CPU strobe high for 1 clk (WE_HOLD=2) -> no write. Address 0x2000 with ADDR_W=13 -> no write, no irq.
- rst_n released while CPU strobe is already held high -> no commit; a fresh 0-to-1 strobe afterwards commits normally.

Source files
------------

// File: rtl/ramdp_mbox.sv
// Dual-port shared RAM between a 32-bit MCU port and a 16-bit cartridge CPU port,
// with qualified CPU writes, byte-lane collision detection and a two-way doorbell.
module ramdp_mbox #(
  parameter int ADDR_W  = 13,
  parameter int CPU_AW  = 24,
  parameter int WE_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mcu_ce,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [31:0]       mcu_dato,
  input  logic [3:0]        mcu_we,
  output logic [31:0]       mcu_dati,
  input  logic              cpu_ce_lo,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [15:0]       cpu_dato,
  input  logic              cpu_we_lo,
  input  logic              cpu_we_hi,
  output logic [15:0]       cpu_dati,
  output logic              mcu_irq,
  output logic              cpu_irq,
  output logic              coll,
  input  logic              coll_clr
);
  localparam int WW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** WW;
  localparam logic [WW-1:0]    DB_MCU_WORD = WW'(DEPTH - 1);
  localparam logic [WW-1:0]    DB_CPU_WORD = WW'(DEPTH - 2);
  localparam logic [WE_HOLD:0] COMMIT_PAT  = {1'b0, {WE_HOLD{1'b1}}};

  logic [WW-1:0]    mcu_word;
  logic [WW-1:0]    cpu_word;
  logic             cpu_in_win;
  logic             cpu_req;
  logic             cpu_commit;
  logic             cpu_wr;
  logic [WE_HOLD:0] hist_reg;
  logic [3:0]       mcu_lane_we;
  logic [3:0]       cpu_lane_we;
  logic [3:0]       coll_lane;
  logic [31:0]      cpu_wdata;
  logic [31:0]      mcu_rd_word;
  logic [31:0]      cpu_rd_word;
  logic             cpu_sel_reg;
  logic             mcu_irq_set, mcu_irq_clr, cpu_irq_set, cpu_irq_clr;
  logic             unused_addr_bits;

  assign mcu_word   = mcu_addr[ADDR_W-1:2];
  assign cpu_word   = cpu_addr[ADDR_W-1:2];
  assign cpu_in_win = (cpu_addr[CPU_AW-1:ADDR_W] == '0);
  assign cpu_req    = cpu_ce_lo & (cpu_we_lo | cpu_we_hi) & cpu_in_win;

  // Commit only on a fresh rising request that has stayed high for WE_HOLD samples.
  assign cpu_commit = (hist_reg == COMMIT_PAT);
  assign cpu_wr     = cpu_commit & cpu_in_win;
  assign cpu_wdata  = {cpu_dato, cpu_dato};

  assign mcu_lane_we = {4{mcu_ce}} & mcu_we;
  assign cpu_lane_we = {4{cpu_wr}} & (cpu_addr[1] ? {cpu_we_hi, cpu_we_lo, 2'b00}
                                                  : {2'b00, cpu_we_hi, cpu_we_lo});
  assign coll_lane   = mcu_lane_we & cpu_lane_we & {4{mcu_word == cpu_word}};

  assign unused_addr_bits = ^{mcu_addr[1:0], cpu_addr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '1;
    end else begin
      hist_reg <= {hist_reg[WE_HOLD-1:0], cpu_req};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] mcu_rd_reg;
      logic [7:0] cpu_rd_reg;

      // CPU write is issued last so it wins a same-word, same-lane collision.
      always_ff @(posedge clk) begin
        if (mcu_lane_we[gi]) mem[mcu_word] <= mcu_dato[8*gi +: 8];
        if (cpu_lane_we[gi]) mem[cpu_word] <= cpu_wdata[8*gi +: 8];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mcu_rd_reg <= '0;
          cpu_rd_reg <= '0;
        end else begin
          mcu_rd_reg <= mem[mcu_word];
          cpu_rd_reg <= mem[cpu_word];
        end
      end

      assign mcu_rd_word[8*gi +: 8] = mcu_rd_reg;
      assign cpu_rd_word[8*gi +: 8] = cpu_rd_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_sel_reg <= 1'b0;
    end else begin
      cpu_sel_reg <= cpu_addr[1];
    end
  end

  assign mcu_dati = mcu_rd_word;
  assign cpu_dati = cpu_sel_reg ? cpu_rd_word[31:16] : cpu_rd_word[15:0];

  assign mcu_irq_set = cpu_wr & (cpu_word == DB_MCU_WORD);
  assign mcu_irq_clr = (|mcu_lane_we) & (mcu_word == DB_MCU_WORD);
  assign cpu_irq_set = (|mcu_lane_we) & (mcu_word == DB_CPU_WORD);
  assign cpu_irq_clr = cpu_wr & (cpu_word == DB_CPU_WORD);

  // In every flag, a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_irq <= 1'b0;
      cpu_irq <= 1'b0;
      coll    <= 1'b0;
    end else begin
      if (mcu_irq_set)      mcu_irq <= 1'b1;
      else if (mcu_irq_clr) mcu_irq <= 1'b0;
      if (cpu_irq_set)      cpu_irq <= 1'b1;
      else if (cpu_irq_clr) cpu_irq <= 1'b0;
      if (|coll_lane)       coll    <= 1'b1;
      else if (coll_clr)    coll    <= 1'b0;
    end
  end
endmodule
